// File: rtl/iir_pkg.sv
// Shared definitions for the lookahead IIR filter path: sample format and the
// occupancy classification used by the output buffer.
package iir_pkg;

    localparam int SAMPLE_W = 9;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Buffer occupancy classes. These are decoded from the level register;
    // no separate state register holds them.
    //   state       | meaning
    //   OCC_EMPTY   | level == 0, vout low
    //   OCC_PARTIAL | 0 < level < DEPTH
    //   OCC_FULL    | level == DEPTH, push without pop is dropped
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    function automatic occ_e occ_state(input int unsigned level,
                                       input int unsigned depth);
        occ_e st;
        if (level == 0) begin
            st = OCC_EMPTY;
        end else if (level >= depth) begin
            st = OCC_FULL;
        end else begin
            st = OCC_PARTIAL;
        end
        return st;
    endfunction

endpackage

// File: rtl/iir_out_buffer_mem.sv
// Sample storage for iir_out_buffer: DEPTH x SAMPLE_W register array with a
// single synchronous write port and an asynchronous read port.
module iir_out_buffer_mem #(
    parameter int SAMPLE_W = 9,
    parameter int DEPTH    = 8
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [SAMPLE_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [SAMPLE_W-1:0]        rdata_o
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iir_out_buffer.sv
// First-word-fall-through elastic buffer behind the IIR core, with sticky
// overflow flag. Define IIR_OUT_BUF_CNT_EN to add the saturating drop counter.
module iir_out_buffer
    import iir_pkg::*;
#(
    parameter int SAMPLE_W = iir_pkg::SAMPLE_W,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [SAMPLE_W-1:0]   din_i,
    input  logic                         vin_i,
    output logic signed [SAMPLE_W-1:0]   dout_o,
    output logic                         vout_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic                         full_o,
    output logic                         overflow_o
`ifdef IIR_OUT_BUF_CNT_EN
    ,
    output logic [CNT_W-1:0]             drop_cnt_o
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                overflow_q, overflow_d;
    occ_e                occ;
    logic                push, pop, drop;
    logic [SAMPLE_W-1:0] rdata;

    always_comb begin
        occ = occ_state(32'(level_q), DEPTH);
    end

    assign vout_o     = (occ != OCC_EMPTY);
    assign full_o     = (occ == OCC_FULL);
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign dout_o     = rdata;

    // A pop frees the head slot in the same cycle, so a full buffer can
    // still accept a push when the consumer is taking a sample.
    assign pop  = vout_o & ready_i;
    assign push = vin_i & (~full_o | pop);
    assign drop = vin_i & full_o & ~pop;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end

        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef IIR_OUT_BUF_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

    iir_out_buffer_mem #(
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push & ~rst_i),
        .waddr_i (wptr_q),
        .wdata_i (din_i),
        .raddr_i (rptr_q),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_iir_out_buffer.sv
// Directed bench for iir_out_buffer (DEPTH=8): vector table for fill/drain and
// overflow, plus sequences for streaming, mid-run reset and counter saturation.
module tb_iir_out_buffer;

    localparam int SAMPLE_W = 9;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = 8;

    logic                clk;
    logic                rst;
    logic [SAMPLE_W-1:0] din;
    logic                vin;
    logic [SAMPLE_W-1:0] dout;
    logic                vout;
    logic                ready;
    logic [3:0]          level;
    logic                full;
    logic                overflow;
`ifdef IIR_OUT_BUF_CNT_EN
    logic [CNT_W-1:0]    drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    iir_out_buffer #(
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .din_i      (din),
        .vin_i      (vin),
        .dout_o     (dout),
        .vout_o     (vout),
        .ready_i    (ready),
        .level_o    (level),
        .full_o     (full),
        .overflow_o (overflow)
`ifdef IIR_OUT_BUF_CNT_EN
        ,
        .drop_cnt_o (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vin;
        logic [8:0] din;
        logic       ready;
        logic       e_vout;
        logic [8:0] e_dout;
        int         e_level;
        logic       e_full;
        logic       e_ovf;
        int         e_drop;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic v, input logic [8:0] d, input logic r,
                           input logic ev, input logic [8:0] ed, input int el,
                           input logic ef, input logic eo, input int edr);
        vec_t t;
        t.vin = v; t.din = d; t.ready = r;
        t.e_vout = ev; t.e_dout = ed; t.e_level = el;
        t.e_full = ef; t.e_ovf = eo; t.e_drop = edr;
        vq.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_drop(input string name, input int exp);
`ifdef IIR_OUT_BUF_CNT_EN
        check(name, int'(drop_cnt), exp);
`endif
    endtask

    // Drive inputs just after an edge, advance one edge, sample 1 ns later.
    task automatic step(input logic r, input logic v, input logic [8:0] d,
                        input logic rd);
        rst = r; vin = v; din = d; ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; vin = 1'b0; din = '0; ready = 1'b0;

        // fill 3, drain 3, then pop on empty
        add_vec(1, 9'h005, 0,  1, 9'h005, 1, 0, 0, 0);
        add_vec(1, 9'h1FF, 0,  1, 9'h005, 2, 0, 0, 0);
        add_vec(1, 9'h100, 0,  1, 9'h005, 3, 0, 0, 0);
        add_vec(0, 9'h000, 1,  1, 9'h1FF, 2, 0, 0, 0);
        add_vec(0, 9'h000, 1,  1, 9'h100, 1, 0, 0, 0);
        add_vec(0, 9'h000, 1,  0, 9'h000, 0, 0, 0, 0);
        add_vec(0, 9'h000, 1,  0, 9'h000, 0, 0, 0, 0);
        // stalled consumer: push 1..10, last two dropped
        for (int i = 1; i <= 8; i++) begin
            add_vec(1, 9'(i), 0,  1, 9'h001, i, (i == 8), 0, 0);
        end
        add_vec(1, 9'h009, 0,  1, 9'h001, 8, 1, 1, 1);
        add_vec(1, 9'h00A, 0,  1, 9'h001, 8, 1, 1, 2);
        // push+pop while full, then drain 2..8 followed by 0x0AA
        add_vec(1, 9'h0AA, 1,  1, 9'h002, 8, 1, 1, 2);
        for (int i = 3; i <= 8; i++) begin
            add_vec(0, 9'h000, 1,  1, 9'(i), 10 - i, 0, 1, 2);
        end
        add_vec(0, 9'h000, 1,  1, 9'h0AA, 1, 0, 1, 2);
        add_vec(0, 9'h000, 1,  0, 9'h000, 0, 0, 1, 2);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset.vout",  int'(vout), 0);
        check("reset.level", int'(level), 0);
        check("reset.full",  int'(full), 0);
        check("reset.ovf",   int'(overflow), 0);
        check_drop("reset.drop", 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(0, vq[i].vin, vq[i].din, vq[i].ready);
            check($sformatf("v%0d.vout", i),  int'(vout), int'(vq[i].e_vout));
            check($sformatf("v%0d.level", i), int'(level), vq[i].e_level);
            check($sformatf("v%0d.full", i),  int'(full), int'(vq[i].e_full));
            check($sformatf("v%0d.ovf", i),   int'(overflow), int'(vq[i].e_ovf));
            check_drop($sformatf("v%0d.drop", i), vq[i].e_drop);
            if (vq[i].e_vout) begin
                check($sformatf("v%0d.dout", i), int'(dout), int'(vq[i].e_dout));
            end
        end

        // streaming: push and pop every cycle, ramp wraps the pointers many times
        for (int i = 0; i < 100; i++) begin
            logic [8:0] d;
            d = 9'(i * 5 + 3);
            step(0, 1, d, 1);
            check($sformatf("ramp%0d.vout", i),  int'(vout), 1);
            check($sformatf("ramp%0d.level", i), int'(level), 1);
            check($sformatf("ramp%0d.dout", i),  int'(dout), int'(d));
        end
        step(0, 0, 0, 1);
        check("ramp.end.level", int'(level), 0);
        check("ramp.end.ovf",   int'(overflow), 1);
        check_drop("ramp.end.drop", 2);

        // reset at level 5 with a push in the same cycle
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 9'(9'h011 + 9'(i)), 0);
        end
        check("prerst.level", int'(level), 5);
        step(1, 1, 9'h077, 0);
        check("rst.level", int'(level), 0);
        check("rst.vout",  int'(vout), 0);
        check("rst.full",  int'(full), 0);
        check("rst.ovf",   int'(overflow), 0);
        check_drop("rst.drop", 0);
        step(0, 0, 0, 0);
        check("postrst.level", int'(level), 0);
        check("postrst.vout",  int'(vout), 0);
        step(0, 1, 9'h033, 0);
        check("postrst.push.level", int'(level), 1);
        check("postrst.push.dout",  int'(dout), 9'h033);
        step(0, 0, 0, 1);
        check("postrst.pop.level", int'(level), 0);

        // fill then 300 drops to saturate the counter
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 9'(9'h040 + 9'(i)), 0);
        end
        for (int i = 0; i < 254; i++) begin
            step(0, 1, 9'h155, 0);
        end
        check_drop("sat.254", 254);
        for (int i = 0; i < 46; i++) begin
            step(0, 1, 9'h155, 0);
        end
        check("sat.level", int'(level), DEPTH);
        check("sat.full",  int'(full), 1);
        check("sat.ovf",   int'(overflow), 1);
        check_drop("sat.300", 255);
        check("sat.head",  int'(dout), 9'h040);
        step(0, 0, 0, 1);
        check("sat.pop.dout",  int'(dout), 9'h041);
        check("sat.pop.level", int'(level), DEPTH - 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_out_buffer.md
# iir_out_buffer

Output elastic buffer sitting directly downstream of the lookahead IIR filter core. It captures each 9-bit filtered sample qualified by the filter's valid strobe. Samples are queued in a small FIFO and presented to the consumer (sink or next processing stage) through a valid/ready handshake, so a stalled consumer never loses filter output until the buffer is full. Overflow is detected and reported, never silently ignored.

## Interface
Parameters:
- SAMPLE_W, 9, sample width in bits (two's complement); must match the filter output width.
- DEPTH, 8, FIFO depth in samples; power of two, 2..64.
- CNT_W, 8, width of the drop counter (used only with the configuration macro).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- din  in  SAMPLE_W  filtered sample from the IIR core.
- vin  in  1  din valid; one sample accepted per cycle with vin=1.
- dout  out  SAMPLE_W  head-of-queue sample.
- vout  out  1  dout valid (queue non-empty).
- ready  in  1  consumer accepts dout in the cycle vout=1 and ready=1.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky: a sample was dropped since reset.
- drop_cnt  out  CNT_W  dropped-sample count (present only with IIR_OUT_BUF_CNT_EN).

## Operation
- Push: vin=1 and (full=0 or pop in same cycle) → din written at write pointer, wptr increments.
- Pop: vout=1 and ready=1 → rptr increments; the next sample appears on dout the following cycle.
- Simultaneous push and pop: allowed at any level including full; level unchanged; when full, the popped slot is the one freed, and the pushed sample is accepted without loss.
- Push when full with no pop: din dropped, FIFO contents unchanged, overflow set to 1 (stays 1 until rst).
- Pop attempted when empty (ready=1, vout=0): no effect.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; level is tracked separately, so full and empty are unambiguous.
- Data is passed unmodified: no rounding, saturation or sign change.
- dout is only meaningful while vout=1; the value shown while vout=0 is unspecified (bench must not check it).
- No states beyond EMPTY (level=0), PARTIAL, and FULL (level=DEPTH), which are derived from level; there is no separate FSM register.

## Timing
- Reset values: vout=0, level=0, full=0, overflow=0, drop_cnt=0, pointers=0; dout unspecified.
- rst asserted mid-operation empties the queue on that edge; vin/ready in that cycle are ignored.
- Latency: a sample pushed at edge k into an empty buffer gives vout=1 with that sample on dout after edge k (one cycle, first-word-fall-through).
- level, full and vout update on the same edge as the push/pop that changes them; all outputs are registered or derived from registered state only, with no combinational path from vin/din/ready to any output.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- IIR_OUT_BUF_CNT_EN defined: drop_cnt port exists; it increments by 1 on every dropped sample and saturates at 2^CNT_W−1.
- Not defined: drop_cnt port and counter are absent; overflow remains the only loss indicator.

## Structure
- Shared package iir_pkg: SAMPLE_W constant (9), sample_t typedef (signed [SAMPLE_W-1:0]), shared with the filter core and data sink.
- One sub-module: iir_out_buffer_mem, a DEPTH×SAMPLE_W register array with one write port and an asynchronous read port. Pointers, level, flags and the counter remain in the top module.

## Test plan
- Reset then push 3 samples (0x005, 0x1FF, 0x100) with ready=0 → level=3, vout=1, dout=0x005; raise ready for 3 cycles → dout sequence 0x005, 0x1FF, 0x100, then vout=0, level=0.
- ready=0, push DEPTH+2 samples 1..10 (DEPTH=8) → full=1 after the 8th, overflow=1, drop_cnt=2 (macro on); drain → values 1..8 exactly.
- While full, vin=1 and ready=1 in the same cycle with din=0x0AA → level stays 8, overflow unchanged, 0x0AA appears last on drain.
- Continuous vin=1 and ready=1 for 100 cycles with a ramp → dout equals din delayed by one cycle, level ≤1, no drops; covers pointer wrap.
- rst pulsed for one cycle at level=5 with vin=1 → next cycle level=0, vout=0, overflow=0, and the sample in that cycle is not stored.
- Macro on, force 300 drops with CNT_W=8 → drop_cnt saturates at 255.
